// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch resolution for the renas cpu.
// Resolves conditional/unconditional branches, produces the resolved next PC,
// a registered one-cycle redirect on misprediction, and buffers predictor
// update records in a FIFO drained over a valid/ready handshake.
// Optional feature macro: BR_STATS_EN (adds br_total/br_wrong counters).
module branch_resolve_unit #(
   parameter int unsigned PC_LENGTH   = 32,
   parameter int unsigned DATA_LENGTH = 32,
   parameter int unsigned CNT_WIDTH   = 2,
   parameter int unsigned HIST_LENGTH = 8,
   parameter int unsigned UPD_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ex_valid,
   input  logic                   branch_capture,
   input  logic                   non_condition,
   input  logic [1:0]             branch_kind,
   input  logic                   eq,
   input  logic                   ge,
   input  logic                   pred_take,
   input  logic [CNT_WIDTH-1:0]   pred_cnt,
   input  logic [HIST_LENGTH-1:0] pred_hist,
   input  logic [DATA_LENGTH-1:0] imm_ex,
   input  logic [DATA_LENGTH-1:0] add_result,
   input  logic [PC_LENGTH-1:0]   pc_ex,
   output logic [PC_LENGTH-1:0]   actual_pc,
   output logic                   stall,
   output logic                   redirect_valid,
   output logic [PC_LENGTH-1:0]   redirect_pc,
   output logic                   upd_valid,
   input  logic                   upd_ready,
   output logic [PC_LENGTH-1:0]   upd_pc,
   output logic [CNT_WIDTH-1:0]   upd_cnt,
   output logic [HIST_LENGTH-1:0] upd_hist,
   output logic                   upd_actual
`ifdef BR_STATS_EN
   ,
   output logic [31:0]            br_total,
   output logic [31:0]            br_wrong
`endif
);

   localparam int unsigned PTR_W = $clog2(UPD_DEPTH);

   typedef enum logic [1:0] {
      EQUAL   = 2'd0,
      N_EQUAL = 2'd1,
      LT      = 2'd2,
      GE      = 2'd3
   } br_kind_e;

   typedef struct packed {
      logic [PC_LENGTH-1:0]   pc;
      logic [CNT_WIDTH-1:0]   cnt;
      logic [HIST_LENGTH-1:0] hist;
      logic                   actual;
   } upd_rec_t;

   br_kind_e               kind;
   logic                   cond;
   logic                   actual;
   logic                   resolve;
   logic                   wrong;
   logic                   enq;
   logic                   deq;
   logic [CNT_WIDTH-1:0]   new_cnt;
   logic [HIST_LENGTH-1:0] new_hist;
   upd_rec_t               new_rec;
   upd_rec_t               head_rec;
   upd_rec_t               mem [UPD_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;

   assign kind = br_kind_e'(branch_kind);

   // Branch condition evaluation from comparator flags
   always_comb begin
      cond = 1'b0;
      if (!non_condition) begin
         case (kind)
            EQUAL:   cond = eq;
            N_EQUAL: cond = ~eq;
            LT:      cond = ~ge;
            GE:      cond = ge;
            default: cond = 1'b0;
         endcase
      end
   end

   assign actual  = non_condition | cond;
   assign stall   = (count == (PTR_W+1)'(UPD_DEPTH));
   // A branch in the shadow of a redirect is on the wrong path and is ignored
   assign resolve = ex_valid & branch_capture & ~stall & ~redirect_valid;
   assign wrong   = resolve & (actual ^ pred_take);
   assign enq     = resolve;
   assign deq     = upd_valid & upd_ready;

   // Resolved next PC, wrapping modulo 2^PC_LENGTH
   always_comb begin
      actual_pc = '0;
      if (non_condition)
         actual_pc = PC_LENGTH'(add_result);
      else if (actual)
         actual_pc = pc_ex + PC_LENGTH'(imm_ex);
      else
         actual_pc = pc_ex + PC_LENGTH'(4);
   end

   // Saturating counter and history update for the predictor record
   always_comb begin
      new_cnt = pred_cnt;
      if (non_condition)
         new_cnt = '1;
      else if (actual && (pred_cnt != '1))
         new_cnt = pred_cnt + 1'b1;
      else if (!actual && (pred_cnt != '0))
         new_cnt = pred_cnt - 1'b1;
      new_hist = {pred_hist[HIST_LENGTH-2:0], actual};
   end

   assign new_rec  = '{pc: pc_ex, cnt: new_cnt, hist: new_hist, actual: actual};
   assign head_rec = mem[rd_ptr];

   assign upd_valid  = (count != '0);
   assign upd_pc     = head_rec.pc;
   assign upd_cnt    = head_rec.cnt;
   assign upd_hist   = head_rec.hist;
   assign upd_actual = head_rec.actual;

   // FIFO storage write (contents need no reset; validity comes from count)
   always_ff @(posedge clk) begin
      if (enq)
         mem[wr_ptr] <= new_rec;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + 1'b1;
         if (deq)
            rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // One-cycle registered redirect on misprediction
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= wrong;
         redirect_pc    <= wrong ? actual_pc : '0;
      end
   end

`ifdef BR_STATS_EN
   // Resolve and mispredict statistics, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         br_total <= '0;
         br_wrong <= '0;
      end else begin
         if (resolve)
            br_total <= br_total + 32'd1;
         if (wrong)
            br_wrong <= br_wrong + 32'd1;
      end
   end
`endif

endmodule
